// File: rtl/rv_pkg.sv
// Shared RV32I definitions: ALU operation codes and the machine word type.
package rv_pkg;

    typedef logic [31:0] word_t;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b1000;
    localparam logic [3:0] ALU_SLL   = 4'b0001;
    localparam logic [3:0] ALU_SLT   = 4'b0010;
    localparam logic [3:0] ALU_SLTU  = 4'b0011;
    localparam logic [3:0] ALU_XOR   = 4'b0100;
    localparam logic [3:0] ALU_SRL   = 4'b0101;
    localparam logic [3:0] ALU_SRA   = 4'b1101;
    localparam logic [3:0] ALU_OR    = 4'b0110;
    localparam logic [3:0] ALU_AND   = 4'b0111;
    localparam logic [3:0] ALU_PASSB = 4'b1001;

    localparam logic SHIFT_RIGHT = 1'b0;
    localparam logic SHIFT_LEFT  = 1'b1;

    function automatic word_t bit_reverse(input word_t w);
        word_t r;
        for (int i = 0; i < 32; i++) begin
            r[i] = w[31-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/alu_shifter.sv
// Five-stage mux barrel shifter shared by SLL, SRL and SRA.
module alu_shifter
    import rv_pkg::*;
(
    input  logic [31:0] data,
    input  logic [4:0]  shamt,
    input  logic        dir,
    input  logic        arith,
    output logic [31:0] result
);

    word_t stg [0:5];
    logic  fill;

    // Left shifts reuse the right-shift network by reversing bit order on the way in and out.
    assign fill   = arith & (dir == SHIFT_RIGHT) & data[31];
    assign stg[0] = (dir == SHIFT_LEFT) ? bit_reverse(data) : data;

    for (genvar i = 0; i < 5; i++) begin : g_stage
        localparam int S = 1 << i;
        assign stg[i+1] = shamt[i] ? {{S{fill}}, stg[i][31:S]} : stg[i];
    end

    assign result = (dir == SHIFT_LEFT) ? bit_reverse(stg[5]) : stg[5];

endmodule

// File: rtl/alu.sv
// RV32I integer ALU: combinational result and zero flag plus a registered trace copy.
module alu
    import rv_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] ASrc,
    input  logic [WIDTH-1:0] BSrc,
    input  logic [3:0]       aluOp,
    output logic [WIDTH-1:0] alures,
    output logic             zero,
    output logic [WIDTH-1:0] alures_q,
    output logic             zero_q
);

    logic        sub_en;
    word_t       b_opnd;
    logic [32:0] sum;
    logic        lt_u;
    logic        lt_s;
    logic        shift_dir;
    logic        shift_arith;
    word_t       shift_res;

    // One adder serves ADD, SUB and both compares; carry-out of A + ~B + 1 is set when A >= B.
    assign sub_en = (aluOp != ALU_ADD);
    assign b_opnd = sub_en ? ~BSrc : BSrc;
    assign sum    = {1'b0, ASrc} + {1'b0, b_opnd} + {32'd0, sub_en};
    assign lt_u   = ~sum[32];
    assign lt_s   = (ASrc[31] != BSrc[31]) ? ASrc[31] : sum[31];

    assign shift_dir   = (aluOp == ALU_SLL) ? SHIFT_LEFT : SHIFT_RIGHT;
    assign shift_arith = (aluOp == ALU_SRA);

    alu_shifter u_shifter (
        .data   (ASrc),
        .shamt  (BSrc[SHAMT_W-1:0]),
        .dir    (shift_dir),
        .arith  (shift_arith),
        .result (shift_res)
    );

    always_comb begin
        alures = '0;
        case (aluOp)
            ALU_ADD,
            ALU_SUB:   alures = sum[31:0];
            ALU_SLT:   alures = {31'd0, lt_s};
            ALU_SLTU:  alures = {31'd0, lt_u};
            ALU_SLL,
            ALU_SRL,
            ALU_SRA:   alures = shift_res;
            ALU_XOR:   alures = ASrc ^ BSrc;
            ALU_OR:    alures = ASrc | BSrc;
            ALU_AND:   alures = ASrc & BSrc;
            ALU_PASSB: alures = BSrc;
            default:   alures = '0;
        endcase
    end

    assign zero = (alures == '0);

    // Trace registers reset to the state of a zero result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alures_q <= '0;
            zero_q   <= 1'b1;
        end else begin
            alures_q <= alures;
            zero_q   <= zero;
        end
    end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed corner cases plus randomized ops against a reference model.
module tb_alu;

    logic        clk;
    logic        rst;
    logic [31:0] ASrc;
    logic [31:0] BSrc;
    logic [3:0]  aluOp;
    logic [31:0] alures;
    logic        zero;
    logic [31:0] alures_q;
    logic        zero_q;

    int n_checks = 0;
    int n_pass   = 0;

    alu dut (
        .clk      (clk),
        .rst      (rst),
        .ASrc     (ASrc),
        .BSrc     (BSrc),
        .aluOp    (aluOp),
        .alures   (alures),
        .zero     (zero),
        .alures_q (alures_q),
        .zero_q   (zero_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] op);
        int unsigned sh;
        sh = b % 32;
        case (op)
            4'd0:    return a + b;
            4'd8:    return a - b;
            4'd1:    return a << sh;
            4'd2:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd3:    return (a < b) ? 32'd1 : 32'd0;
            4'd4:    return a ^ b;
            4'd5:    return a >> sh;
            4'd13:   return 32'($signed(a) >>> sh);
            4'd6:    return a | b;
            4'd7:    return a & b;
            4'd9:    return b;
            default: return 32'd0;
        endcase
    endfunction

    // Apply operands away from the clock edge and check the combinational outputs.
    task automatic apply(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] op, input logic [31:0] exp);
        ASrc  = a;
        BSrc  = b;
        aluOp = op;
        #1;
        check(tag, alures, exp);
        check({tag, "_zero"}, {31'd0, zero}, {31'd0, exp == 32'd0});
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'h7FFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] a, b, exp;
        logic [3:0]  op;

        rst   = 1'b1;
        ASrc  = '0;
        BSrc  = '0;
        aluOp = '0;
        #3;
        check("reset_q", alures_q, 32'd0);
        check("reset_zq", {31'd0, zero_q}, 32'd1);
        @(negedge clk);
        rst = 1'b0;

        // Directed corner cases
        apply("add_wrap", 32'hFFFF_FFFF, 32'h1, 4'b0000, 32'h0);
        @(posedge clk); #1;
        check("add_wrap_q", alures_q, 32'h0);
        check("add_wrap_zq", {31'd0, zero_q}, 32'd1);
        @(negedge clk);
        apply("sub", 32'd5, 32'd7, 4'b1000, 32'hFFFF_FFFE);
        apply("slt", 32'd5, 32'd7, 4'b0010, 32'd1);
        apply("sltu", 32'd5, 32'd7, 4'b0011, 32'd1);
        apply("slt_neg", 32'h8000_0000, 32'd1, 4'b0010, 32'd1);
        apply("sltu_big", 32'h8000_0000, 32'd1, 4'b0011, 32'd0);
        apply("sll4", 32'h8000_0001, 32'hFFFF_FFE4, 4'b0001, 32'h0000_0010);
        apply("srl4", 32'h8000_0001, 32'hFFFF_FFE4, 4'b0101, 32'h0800_0000);
        apply("sra4", 32'h8000_0001, 32'hFFFF_FFE4, 4'b1101, 32'hF800_0000);
        apply("sll0", 32'h8000_0001, 32'h0, 4'b0001, 32'h8000_0001);
        apply("srl0", 32'h8000_0001, 32'h0, 4'b0101, 32'h8000_0001);
        apply("sra0", 32'h8000_0001, 32'h0, 4'b1101, 32'h8000_0001);
        apply("xor", 32'hF0F0_F0F0, 32'h0FF0_0FF0, 4'b0100, 32'hFF00_FF00);
        apply("or", 32'hF0F0_F0F0, 32'h0FF0_0FF0, 4'b0110, 32'hFFF0_FFF0);
        apply("and", 32'hF0F0_F0F0, 32'h0FF0_0FF0, 4'b0111, 32'h00F0_00F0);
        apply("passb", 32'hF0F0_F0F0, 32'h0FF0_0FF0, 4'b1001, 32'h0FF0_0FF0);
        apply("unused", 32'hF0F0_F0F0, 32'h0FF0_0FF0, 4'b1111, 32'h0);

        // Asynchronous reset in mid-cycle touches only the registered copy
        @(negedge clk);
        apply("rst_add", 32'd3, 32'd4, 4'b0000, 32'd7);
        @(posedge clk); #1;
        check("rst_pre_q", alures_q, 32'd7);
        #2 rst = 1'b1;
        #1;
        check("rst_async_q", alures_q, 32'd0);
        check("rst_async_zq", {31'd0, zero_q}, 32'd1);
        check("rst_comb", alures, 32'd7);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        check("rst_rel_q", alures_q, 32'd7);
        check("rst_rel_zq", {31'd0, zero_q}, 32'd0);

        // Randomized vectors
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            a  = pick_operand();
            b  = pick_operand();
            op = 4'($urandom_range(0, 15));
            case ($urandom_range(0, 3))
                0:       b[4:0] = 5'd0;
                1:       b[4:0] = 5'd31;
                default: ;
            endcase
            exp = ref_alu(a, b, op);
            apply("rand", a, b, op, exp);
            @(posedge clk); #1;
            check("rand_q", alures_q, exp);
            check("rand_zq", {31'd0, zero_q}, {31'd0, exp == 32'd0});
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
